// File: rtl/ld_pkg.sv
// Shared types and sizing for the sequential long divider (long_div_seq).
// Holds the FSM state encoding, default widths and, with
// LONG_DIV_SKIP_LZ_EN defined, the significant-bit counter used at accept.
package ld_pkg;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_RUN  = 1'b1
    } ld_state_t;

    localparam int LD_W  = 32;
    localparam int LD_LW = 8;
    localparam int LD_CW = $clog2(LD_W + 2**LD_LW);

`ifdef LONG_DIV_SKIP_LZ_EN
    // Widest operand the significant-bit counter accepts.
    localparam int LD_MAXW = 64;

    // Number of significant bits (index of MSB set, plus one); 0 for x==0.
    function automatic int unsigned ld_sig_bits(
        input logic [LD_MAXW-1:0] x
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < LD_MAXW; i++) begin
            if (x[i]) n = i + 1;
        end
        return n;
    endfunction
`endif

endpackage

// File: rtl/ld_csub.sv
// Combinational compare-and-conditional-subtract step of restoring division.
// Ports: rem (W) running remainder, dbit next dividend bit, mod (W) divisor,
//        rem_next (W) = {rem,dbit} reduced once by mod.
module ld_csub #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         dbit,
    input  logic [W-1:0] mod,
    output logic [W-1:0] rem_next
);

    logic [W:0] t;
    logic [W:0] m;
    logic [W:0] d;

    assign t = {rem, dbit};
    assign m = {1'b0, mod};
    assign d = t - m;

    // rem < mod keeps the reduced value inside W bits.
    assign rem_next = (t >= m) ? d[W-1:0] : t[W-1:0];

endmodule

// File: rtl/long_div_seq.sv
// Sequential long divider: ld_out = (num_in * 2^len) mod modulus, one bit/clock.
// Ports: clk, rstn (async low), md_start/md_busy/md_end handshake, len, num_in,
//        modulus, ld_out result, md_err (modulus was 0). Option: LONG_DIV_SKIP_LZ_EN.
module long_div_seq
    import ld_pkg::*;
#(
    parameter int W  = LD_W,
    parameter int LW = LD_LW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          md_start,
    input  logic [LW-1:0] len,
    input  logic [W-1:0]  num_in,
    input  logic [W-1:0]  modulus,
    output logic          md_busy,
    output logic          md_end,
    output logic [W-1:0]  ld_out,
    output logic          md_err
);

    localparam int CW = $clog2(W + 2**LW);

    ld_state_t     state;
    logic [W-1:0]  sh;
    logic [W-1:0]  rem;
    logic [W-1:0]  mod_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  sh_init;
    logic [CW-1:0] cnt_init;

    // The shift register drains to zero after num_in's bits, so its MSB
    // naturally supplies the trailing len zero bits.
    ld_csub #(.W(W)) u_csub (
        .rem      (rem),
        .dbit     (sh[W-1]),
        .mod      (mod_q),
        .rem_next (rem_nx)
    );

`ifdef LONG_DIV_SKIP_LZ_EN
    int unsigned sig;

    always_comb begin
        sig      = ld_sig_bits(LD_MAXW'(num_in));
        sh_init  = num_in << (W - int'(sig));
        cnt_init = CW'(sig) + CW'(len);
        if (cnt_init == '0) cnt_init = CW'(1);
    end
`else
    always_comb begin
        sh_init  = num_in;
        cnt_init = CW'(W) + CW'(len);
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= LD_IDLE;
            sh      <= '0;
            rem     <= '0;
            mod_q   <= '0;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_end  <= 1'b0;
            md_err  <= 1'b0;
            ld_out  <= '0;
        end else begin
            md_end <= 1'b0;
            unique case (state)
                LD_IDLE: begin
                    if (md_start) begin
                        sh      <= sh_init;
                        mod_q   <= modulus;
                        rem     <= '0;
                        cnt     <= cnt_init;
                        md_err  <= 1'b0;
                        md_busy <= 1'b1;
                        state   <= LD_RUN;
                    end
                end
                LD_RUN: begin
                    if (mod_q == '0) begin
                        md_err  <= 1'b1;
                        ld_out  <= '0;
                        md_end  <= 1'b1;
                        md_busy <= 1'b0;
                        state   <= LD_IDLE;
                    end else begin
                        rem <= rem_nx;
                        sh  <= sh << 1;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            ld_out  <= rem_nx;
                            md_end  <= 1'b1;
                            md_busy <= 1'b0;
                            state   <= LD_IDLE;
                        end
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_long_div_seq.sv
// Directed bench for long_div_seq (W=32, LW=8): results, latency,
// busy length, error flag, ignored restart, back-to-back start, async reset.
module tb_long_div_seq;

    logic        clk;
    logic        rstn;
    logic        md_start;
    logic [7:0]  len;
    logic [31:0] num_in;
    logic [31:0] modulus;
    logic        md_busy;
    logic        md_end;
    logic [31:0] ld_out;
    logic        md_err;

    int nassert;
    int nfail;
    int elapsed;
    int bcnt;

    long_div_seq #(.W(32), .LW(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .md_start (md_start),
        .len      (len),
        .num_in   (num_in),
        .modulus  (modulus),
        .md_busy  (md_busy),
        .md_end   (md_end),
        .ld_out   (ld_out),
        .md_err   (md_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        elapsed++;
        if (md_busy) bcnt++;
    endtask

    task automatic start_now(input string tag, input logic [31:0] n,
                             input logic [7:0] l, input logic [31:0] m);
        num_in   = n;
        len      = l;
        modulus  = m;
        md_start = 1'b1;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        elapsed  = 0;
        bcnt     = md_busy ? 1 : 0;
        chk({tag, "_busy_at_accept"}, 64'(md_busy), 64'd1);
        chk({tag, "_err_at_accept"}, 64'(md_err), 64'd0);
    endtask

    task automatic start(input string tag, input logic [31:0] n,
                         input logic [7:0] l, input logic [31:0] m);
        @(negedge clk);
        start_now(tag, n, l, m);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_out,
                             input logic exp_err, input int lat_fix,
                             input int lat_skip);
        int lat;
`ifdef LONG_DIV_SKIP_LZ_EN
        lat = lat_skip;
`else
        lat = lat_fix;
`endif
        while (!md_end && elapsed < 2000) step();
        chk({tag, "_latency"}, 64'(elapsed), 64'(lat));
        chk({tag, "_ld_out"}, 64'(ld_out), 64'(exp_out));
        chk({tag, "_err"}, 64'(md_err), 64'(exp_err));
        chk({tag, "_busy_at_end"}, 64'(md_busy), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(lat));
    endtask

    initial begin
        nassert  = 0;
        nfail    = 0;
        elapsed  = 0;
        bcnt     = 0;
        rstn     = 1'b0;
        md_start = 1'b0;
        len      = '0;
        num_in   = '0;
        modulus  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_end", 64'(md_end), 64'd0);
        chk("rst_err", 64'(md_err), 64'd0);
        chk("rst_out", 64'(ld_out), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // 5*16 mod 7 = 3
        start("v5", 32'd5, 8'd4, 32'd7);
        wait_done("v5", 32'd3, 1'b0, 36, 7);

        // 0xFFFFFFFF = N+4, 2^32 = N+5 -> 20
        start("vff", 32'hFFFF_FFFF, 8'd32, 32'hFFFF_FFFB);
        wait_done("vff", 32'h14, 1'b0, 64, 64);

        start("mod0", 32'd1234, 8'd17, 32'd0);
        wait_done("mod0", 32'd0, 1'b1, 1, 1);

        // 100 mod 7 = 2, also clears md_err
        start("v100", 32'd100, 8'd0, 32'd7);
        wait_done("v100", 32'd2, 1'b0, 32, 7);

        start("mod1", 32'd12345, 8'd3, 32'd1);
        wait_done("mod1", 32'd0, 1'b0, 35, 17);

        start("v50", 32'd50, 8'd0, 32'd7);
        wait_done("v50", 32'd1, 1'b0, 32, 6);

        // 2^255 mod (2^32-1) = 2^(255 mod 32) = 2^31
        start("len255", 32'd1, 8'd255, 32'hFFFF_FFFF);
        wait_done("len255", 32'h8000_0000, 1'b0, 287, 256);

        start("zero", 32'd0, 8'd0, 32'd5);
        wait_done("zero", 32'd0, 1'b0, 32, 1);

        start("zerolen", 32'd0, 8'd7, 32'd9);
        wait_done("zerolen", 32'd0, 1'b0, 39, 7);

        // Restart at t0+5 with other operands must be ignored.
        start("ign", 32'd5, 8'd4, 32'd7);
        repeat (4) step();
        num_in   = 32'd1;
        len      = 8'd0;
        modulus  = 32'd3;
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        chk("ign_busy_t5", 64'(md_busy), 64'd1);
        wait_done("ign", 32'd3, 1'b0, 36, 7);

        // Start in the md_end cycle: 10*2 mod 6 = 2
        start_now("b2b", 32'd10, 8'd1, 32'd6);
        wait_done("b2b", 32'd2, 1'b0, 33, 5);

        // Asynchronous reset in mid-operation.
        start("rst", 32'hFFFF_FFFF, 8'd32, 32'hFFFF_FFFB);
        repeat (9) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_busy", 64'(md_busy), 64'd0);
        chk("arst_end", 64'(md_end), 64'd0);
        chk("arst_out", 64'(ld_out), 64'd0);
        chk("arst_err", 64'(md_err), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_end", 64'(md_end), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst_idle_end", 64'(md_end), 64'd0);

        // 256 mod 1000 = 256
        start("post", 32'd1, 8'd8, 32'd1000);
        wait_done("post", 32'd256, 1'b0, 40, 9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule
